message_player: RTL and testbench

- Transmit-side counterpart of the bus-to-packet message buffer.
- Accepts one complete packet from the NIC receive path, holds it in a local buffer, decodes the head flit, and replays it as a Wishbone classic/incrementing burst on the master bus port, one beat per ACK.
- Sits between the ejection-side packet queue and the NIC's Wishbone master interface.

---
 rtl/message_player.sv | 205 ++++++++++++++++++++
 tb/tb_message_player.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/message_player.sv
// Replays one buffered NoC packet as a Wishbone incrementing burst, one beat per ACK.
// Malformed packets and bus errors are reported with a single-cycle error pulse.
module message_player #(
  parameter int FLIT_WIDTH          = 64,
  parameter int MAX_BURST_LENGHT    = 8,
  parameter int MAX_PACKET_LENGHT   = 9,
  parameter int N_BITS_BURST_LENGHT = 5,
  parameter int BUS_ADDRESS_WIDTH   = 32,
  parameter int BUS_DATA_WIDTH      = 32,
  parameter int BUS_SEL_WIDTH       = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt_i,
  input  logic                                    is_valid_i,
  output logic                                    ready_o,
  output logic [BUS_ADDRESS_WIDTH-1:0]            ADR_O,
  output logic [BUS_DATA_WIDTH-1:0]               DAT_O,
  output logic [BUS_SEL_WIDTH-1:0]                SEL_O,
  output logic                                    WE_O,
  output logic                                    CYC_O,
  output logic                                    STB_O,
  output logic [2:0]                              CTI_O,
  input  logic                                    ACK_I,
  input  logic                                    ERR_I,
  output logic                                    done_o,
  output logic                                    error_o
);

  localparam int N     = N_BITS_BURST_LENGHT;
  localparam int IDX_W = (MAX_BURST_LENGHT > 1) ? $clog2(MAX_BURST_LENGHT) : 1;

  localparam logic [N-1:0] LEN_ZERO = {N{1'b0}};
  localparam logic [N-1:0] LEN_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] LEN_MAX  = N'(MAX_BURST_LENGHT);

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  localparam logic [1:0] TYPE_HEAD      = 2'b00;
  localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BURST = 2'b01,
    DROP  = 2'b10
  } state_t;

  state_t                       state_r;
  logic [N-1:0]                 b_r;
  logic [N-1:0]                 len_r;
  logic                         we_r;
  logic [BUS_ADDRESS_WIDTH-1:0] start_r;
  logic [BUS_DATA_WIDTH-1:0]    data_buf_r [MAX_BURST_LENGHT];
  logic [BUS_SEL_WIDTH-1:0]     sel_buf_r  [MAX_BURST_LENGHT];

  logic [FLIT_WIDTH-1:0]        head_s;
  logic [1:0]                   head_type_s;
  logic                         head_we_s;
  logic [N-1:0]                 head_len_s;
  logic [BUS_ADDRESS_WIDTH-1:0] head_addr_s;
  logic                         pkt_ok_s;
  logic [BUS_DATA_WIDTH-1:0]    first_data_s;
  logic [BUS_SEL_WIDTH-1:0]     first_sel_s;

  logic [N-1:0]                 next_b_s;
  logic [IDX_W-1:0]             next_idx_s;
  logic                         last_s;
  logic                         next_last_s;
  logic [BUS_ADDRESS_WIDTH-1:0] next_adr_s;
  logic [BUS_DATA_WIDTH-1:0]    next_dat_s;
  logic [BUS_SEL_WIDTH-1:0]     next_sel_s;

  assign head_s       = pkt_i[FLIT_WIDTH-1:0];
  assign first_data_s = pkt_i[FLIT_WIDTH +: BUS_DATA_WIDTH];
  assign first_sel_s  = pkt_i[FLIT_WIDTH+BUS_DATA_WIDTH +: BUS_SEL_WIDTH];

  // Decode the head flit and classify the packet as a legal write, a legal read or malformed.
  always_comb begin
    head_type_s = head_s[1:0];
    head_we_s   = head_s[2];
    head_len_s  = head_s[2+N:3];
    head_addr_s = head_s[BUS_ADDRESS_WIDTH+7:8];
    pkt_ok_s    = 1'b0;
    if ((head_len_s != LEN_ZERO) && (head_len_s <= LEN_MAX)) begin
      if (head_we_s) begin
        pkt_ok_s = (head_type_s == TYPE_HEAD);
      end else begin
        pkt_ok_s = (head_type_s == TYPE_HEAD_TAIL);
      end
    end else begin
      pkt_ok_s = 1'b0;
    end
  end

  // Precompute the bus values of the beat following the current one.
  always_comb begin
    next_b_s    = b_r + LEN_ONE;
    next_idx_s  = next_b_s[IDX_W-1:0];
    last_s      = (b_r == (len_r - LEN_ONE));
    next_last_s = (next_b_s == (len_r - LEN_ONE));
    next_adr_s  = start_r + (BUS_ADDRESS_WIDTH'(next_b_s) * BUS_ADDRESS_WIDTH'(BUS_SEL_WIDTH));
    if (we_r) begin
      next_dat_s = data_buf_r[next_idx_s];
      next_sel_s = sel_buf_r[next_idx_s];
    end else begin
      next_dat_s = {BUS_DATA_WIDTH{1'b0}};
      next_sel_s = {BUS_SEL_WIDTH{1'b1}};
    end
  end

  // Control FSM with every output registered; bus outputs are loaded one beat ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      b_r     <= LEN_ZERO;
      len_r   <= LEN_ZERO;
      we_r    <= 1'b0;
      start_r <= {BUS_ADDRESS_WIDTH{1'b0}};
      ready_o <= 1'b1;
      done_o  <= 1'b0;
      error_o <= 1'b0;
      ADR_O   <= {BUS_ADDRESS_WIDTH{1'b0}};
      DAT_O   <= {BUS_DATA_WIDTH{1'b0}};
      SEL_O   <= {BUS_SEL_WIDTH{1'b0}};
      WE_O    <= 1'b0;
      CYC_O   <= 1'b0;
      STB_O   <= 1'b0;
      CTI_O   <= 3'b000;
    end else begin
      done_o  <= 1'b0;
      error_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (is_valid_i) begin
            ready_o <= 1'b0;
            if (pkt_ok_s) begin
              state_r <= BURST;
              b_r     <= LEN_ZERO;
              len_r   <= head_len_s;
              we_r    <= head_we_s;
              start_r <= head_addr_s;
              for (int k = 0; k < MAX_BURST_LENGHT; k++) begin
                data_buf_r[k] <= pkt_i[FLIT_WIDTH*(k+1) +: BUS_DATA_WIDTH];
                sel_buf_r[k]  <= pkt_i[FLIT_WIDTH*(k+1)+BUS_DATA_WIDTH +: BUS_SEL_WIDTH];
              end
              CYC_O <= 1'b1;
              STB_O <= 1'b1;
              WE_O  <= head_we_s;
              ADR_O <= head_addr_s;
              DAT_O <= head_we_s ? first_data_s : {BUS_DATA_WIDTH{1'b0}};
              SEL_O <= head_we_s ? first_sel_s : {BUS_SEL_WIDTH{1'b1}};
              CTI_O <= (head_len_s == LEN_ONE) ? CTI_END : CTI_INCR;
            end else begin
              state_r <= DROP;
              error_o <= 1'b1;
            end
          end else begin
            ready_o <= 1'b1;
          end
        end
        BURST: begin
          // ERR_I wins over ACK_I; the remaining beats are abandoned.
          if (ERR_I || (ACK_I && last_s)) begin
            state_r <= ERR_I ? DROP : IDLE;
            ready_o <= !ERR_I;
            error_o <= ERR_I;
            done_o  <= !ERR_I;
            ADR_O   <= {BUS_ADDRESS_WIDTH{1'b0}};
            DAT_O   <= {BUS_DATA_WIDTH{1'b0}};
            SEL_O   <= {BUS_SEL_WIDTH{1'b0}};
            WE_O    <= 1'b0;
            CYC_O   <= 1'b0;
            STB_O   <= 1'b0;
            CTI_O   <= 3'b000;
          end else if (ACK_I) begin
            b_r   <= next_b_s;
            ADR_O <= next_adr_s;
            DAT_O <= next_dat_s;
            SEL_O <= next_sel_s;
            CTI_O <= next_last_s ? CTI_END : CTI_INCR;
          end else begin
            b_r <= b_r;
          end
        end
        DROP: begin
          state_r <= IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          ready_o <= 1'b1;
          ADR_O   <= {BUS_ADDRESS_WIDTH{1'b0}};
          DAT_O   <= {BUS_DATA_WIDTH{1'b0}};
          SEL_O   <= {BUS_SEL_WIDTH{1'b0}};
          WE_O    <= 1'b0;
          CYC_O   <= 1'b0;
          STB_O   <= 1'b0;
          CTI_O   <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_message_player.sv
// Directed self-checking bench for message_player: writes, wrapping read,
// malformed packets, bus error abort and mid-burst reset.
module tb_message_player;

  localparam int PW = 9 * 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pkt_i = '0;
  logic          is_valid_i = 1'b0;
  logic          ready_o;
  logic [31:0]   ADR_O;
  logic [31:0]   DAT_O;
  logic [3:0]    SEL_O;
  logic          WE_O, CYC_O, STB_O;
  logic [2:0]    CTI_O;
  logic          ACK_I = 1'b0;
  logic          ERR_I = 1'b0;
  logic          done_o, error_o;

  int errors = 0;
  int checks = 0;

  message_player dut (
    .clk(clk), .rst(rst), .pkt_i(pkt_i), .is_valid_i(is_valid_i), .ready_o(ready_o),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O), .CYC_O(CYC_O),
    .STB_O(STB_O), .CTI_O(CTI_O), .ACK_I(ACK_I), .ERR_I(ERR_I),
    .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] make_pkt(input logic we, input logic [1:0] typ,
      input logic [4:0] len, input logic [31:0] addr, input logic [31:0] base,
      input logic [3:0] sel);
    logic [PW-1:0] p;
    p = '0;
    p[1:0]  = typ;
    p[2]    = we;
    p[7:3]  = len;
    p[39:8] = addr;
    for (int k = 1; k <= 8; k++) begin
      p[64*k +: 32]      = base + 32'(k - 1);
      p[64*k + 32 +: 4]  = sel;
    end
    return p;
  endfunction

  // Present a packet for one accepting edge, then withdraw it.
  task automatic send(input logic [PW-1:0] p);
    pkt_i = p;
    is_valid_i = 1'b1;
    step();
    is_valid_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_cyc"}, 64'(CYC_O), 64'd0);
    check_eq({tag, "_adr"}, 64'(ADR_O), 64'd0);
    check_eq({tag, "_rdy"}, 64'(ready_o), 64'd1);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    check_idle("reset");
    check_eq("reset_done", 64'(done_o), 64'd0);
    check_eq("reset_err", 64'(error_o), 64'd0);

    // Single write beat
    ACK_I = 1'b1;
    send(make_pkt(1'b1, 2'b00, 5'd1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF));
    check_eq("w1_cyc", 64'(CYC_O), 64'd1);
    check_eq("w1_stb", 64'(STB_O), 64'd1);
    check_eq("w1_we", 64'(WE_O), 64'd1);
    check_eq("w1_adr", 64'(ADR_O), 64'h1000);
    check_eq("w1_dat", 64'(DAT_O), 64'hDEAD_BEEF);
    check_eq("w1_sel", 64'(SEL_O), 64'hF);
    check_eq("w1_cti", 64'(CTI_O), 64'd7);
    check_eq("w1_rdy", 64'(ready_o), 64'd0);
    step();
    check_eq("w1_done", 64'(done_o), 64'd1);
    check_idle("w1_after");
    step();
    check_eq("w1_done_off", 64'(done_o), 64'd0);

    // 4-beat write with ACK toggling 1,0,1,0,...: 7 burst cycles
    ACK_I = 1'b0;
    send(make_pkt(1'b1, 2'b00, 5'd4, 32'h0000_2000, 32'h1111_0000, 4'h3));
    for (int c = 0; c < 7; c++) begin
      int bi;
      bi = (c + 1) / 2;
      ACK_I = (c % 2 == 0);
      check_eq("w4_cyc", 64'(CYC_O), 64'd1);
      check_eq("w4_adr", 64'(ADR_O), 64'h2000 + 64'(4 * bi));
      check_eq("w4_dat", 64'(DAT_O), 64'h1111_0000 + 64'(bi));
      check_eq("w4_sel", 64'(SEL_O), 64'h3);
      check_eq("w4_cti", 64'(CTI_O), (bi == 3) ? 64'd7 : 64'd2);
      check_eq("w4_done_early", 64'(done_o), 64'd0);
      step();
    end
    check_eq("w4_done", 64'(done_o), 64'd1);
    check_idle("w4_after");

    // 8-beat read wrapping the address space
    ACK_I = 1'b1;
    send(make_pkt(1'b0, 2'b11, 5'd8, 32'hFFFF_FFF8, 32'h5555_0000, 4'h1));
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ea;
      ea = 32'hFFFF_FFF8 + 32'(4 * i);
      check_eq("rd_cyc", 64'(CYC_O), 64'd1);
      check_eq("rd_we", 64'(WE_O), 64'd0);
      check_eq("rd_sel", 64'(SEL_O), 64'hF);
      check_eq("rd_dat", 64'(DAT_O), 64'd0);
      check_eq("rd_adr", 64'(ADR_O), 64'(ea));
      check_eq("rd_cti", 64'(CTI_O), (i == 7) ? 64'd7 : 64'd2);
      step();
    end
    check_eq("rd_done", 64'(done_o), 64'd1);
    check_idle("rd_after");

    // Malformed packets: L=0, L=9, write tagged HEAD_TAIL
    for (int m = 0; m < 3; m++) begin
      logic [PW-1:0] bad;
      case (m)
        0:       bad = make_pkt(1'b1, 2'b00, 5'd0, 32'h100, 32'h0, 4'hF);
        1:       bad = make_pkt(1'b1, 2'b00, 5'd9, 32'h100, 32'h0, 4'hF);
        default: bad = make_pkt(1'b1, 2'b11, 5'd2, 32'h100, 32'h0, 4'hF);
      endcase
      send(bad);
      check_eq("bad_cyc", 64'(CYC_O), 64'd0);
      check_eq("bad_err", 64'(error_o), 64'd1);
      check_eq("bad_rdy", 64'(ready_o), 64'd0);
      step();
      check_eq("bad_err_off", 64'(error_o), 64'd0);
      check_eq("bad_done", 64'(done_o), 64'd0);
      check_idle("bad_after");
    end

    // ERR_I on beat 2 of a 4-beat write
    ACK_I = 1'b1;
    send(make_pkt(1'b1, 2'b00, 5'd4, 32'h0000_3000, 32'hA000_0000, 4'hF));
    step();
    check_eq("err_beat2_adr", 64'(ADR_O), 64'h3004);
    ERR_I = 1'b1;
    step();
    ERR_I = 1'b0;
    check_eq("err_cyc", 64'(CYC_O), 64'd0);
    check_eq("err_pulse", 64'(error_o), 64'd1);
    check_eq("err_done", 64'(done_o), 64'd0);
    step();
    check_eq("err_pulse_off", 64'(error_o), 64'd0);
    check_eq("err_done2", 64'(done_o), 64'd0);
    check_idle("err_after");
    send(make_pkt(1'b1, 2'b00, 5'd1, 32'h0000_3100, 32'hCAFE_F00D, 4'h9));
    check_eq("err_next_adr", 64'(ADR_O), 64'h3100);
    check_eq("err_next_dat", 64'(DAT_O), 64'hCAFE_F00D);
    check_eq("err_next_sel", 64'(SEL_O), 64'h9);
    step();
    check_eq("err_next_done", 64'(done_o), 64'd1);

    // Reset during beat 3 of an 8-beat write
    step();
    send(make_pkt(1'b1, 2'b00, 5'd8, 32'h0000_4000, 32'hB000_0000, 4'hF));
    step();
    step();
    check_eq("rst_beat3_adr", 64'(ADR_O), 64'h4008);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("rst_mid");
    check_eq("rst_mid_done", 64'(done_o), 64'd0);
    send(make_pkt(1'b1, 2'b00, 5'd1, 32'h0000_5000, 32'h1234_5678, 4'h5));
    check_eq("rst_next_cyc", 64'(CYC_O), 64'd1);
    check_eq("rst_next_adr", 64'(ADR_O), 64'h5000);
    check_eq("rst_next_dat", 64'(DAT_O), 64'h1234_5678);
    check_eq("rst_next_sel", 64'(SEL_O), 64'h5);
    check_eq("rst_next_cti", 64'(CTI_O), 64'd7);
    step();
    check_eq("rst_next_done", 64'(done_o), 64'd1);
    check_idle("rst_next_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
